// File: rtl/efuse_ctrl_pkg.sv
// Shared types and helpers for the parametrised eFuse controller.
package efuse_ctrl_pkg;

  // Widths of the macro timing fields (read and program strobe lengths).
  localparam int TRD_W  = 6;
  localparam int TPGM_W = 10;

  typedef enum logic [3:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    RD_CAPT,
    PG_SCAN,
    PG_SETUP,
    PG_STROBE,
    PG_HOLD,
    DONE
  } state_t;

  // What the current busy period is doing; decides what happens after the last byte.
  typedef enum logic [1:0] {
    MODE_AUTO,
    MODE_READ,
    MODE_WRITE
  } mode_t;

  // Number of macro bytes covered by a window of win_bits bits.
  function automatic int win_bytes(input int win_bits);
    return win_bits / 8;
  endfunction

endpackage

// File: rtl/efuse_strobe_timer.sv
// Loadable down-counter timing the macro strobe; a length of 0 behaves as 1.
module efuse_strobe_timer
  import efuse_ctrl_pkg::*;
#(
  parameter int W = TPGM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Load in the setup cycle, then count down once per strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (len == '0) ? W'(1) : len;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Expiry marks the final strobe cycle.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/efuse_ctrl_pv.sv
// eFuse controller: autoload into a shadow register, windowed read refresh,
// and windowed program with verify and bounded per-bit retry.
module efuse_ctrl_pv
  import efuse_ctrl_pkg::*;
#(
  parameter int          NBITS     = 256,
  parameter int          NW        = 64,
  parameter int          NR        = 64,
  parameter int          MAX_RETRY = 2,
  parameter logic [15:0] KEY       = 16'h55AA,
  parameter int          AW        = $clog2(NBITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          autoload_start,
  input  logic                          cmd_start,
  input  logic                          cmd_write,
  input  logic [15:0]                   password,
  input  logic [NW-1:0]                 wdata,
  input  logic [$clog2(NBITS/NR)-1:0]   read_sel,
  input  logic [$clog2(NBITS/NW)-1:0]   write_sel,
  input  logic [TRD_W-1:0]              trd,
  input  logic [TPGM_W-1:0]             tpgm,
  output logic [NR-1:0]                 rdata,
  output logic                          efuse_pgmen_o,
  output logic                          efuse_rden_o,
  output logic                          efuse_aen_o,
  output logic [AW-1:0]                 efuse_addr_o,
  input  logic [7:0]                    efuse_rdata_i,
  output logic                          autoload_done,
  output logic                          busy,
  output logic                          cmd_done,
  output logic                          verify_err,
  output logic                          pwd_err
);

  localparam int NBYTES   = NBITS / 8;
  localparam int BW       = AW - 3;
  localparam int NWB      = $clog2(NW);
  localparam int WSW      = $clog2(NBITS / NW);
  localparam int NW_BYTES = win_bytes(NW);
  localparam int NR_BYTES = win_bytes(NR);

  state_t            state, state_nxt;
  mode_t             mode;
  logic [BW-1:0]     byte_idx, byte_last;
  logic [NWB-1:0]    bit_idx;
  logic [NW-1:0]     wdata_q, pg_mask;
  logic [WSW-1:0]    wsel_q;
  logic [7:0]        attempt;
  logic [NBITS-1:0]  shadow, shadow_nxt;

  logic              idle, start_al, start_cmd, start_rd, start_wr, pwd_bad;
  logic              last_byte, bit_last, bit_step;
  logic [AW-1:0]     rd_bit_base, wr_bit_base;
  logic [NW-1:0]     win_now, fail_vec;
  logic              fail_any, retry_ok;
  logic              tmr_load, tmr_exp;
  logic [TPGM_W-1:0] tmr_len;

  // Start decode: autoload has priority, and nothing starts while busy.
  assign idle      = (state == IDLE);
  assign start_al  = idle && autoload_start;
  assign start_cmd = idle && cmd_start && !autoload_start;
  assign start_rd  = start_cmd && !cmd_write;
  assign start_wr  = start_cmd && cmd_write && (password == KEY);
  assign pwd_bad   = start_cmd && cmd_write && (password != KEY);

  assign rd_bit_base = AW'(int'(read_sel) * NR);
  assign wr_bit_base = AW'(int'(wsel_q) * NW);
  assign rdata       = shadow[rd_bit_base +: NR];

  assign last_byte = (byte_idx == byte_last);
  assign bit_last  = (bit_idx == NWB'(NW - 1));
  assign bit_step  = ((state == PG_SCAN) && !pg_mask[bit_idx]) || (state == PG_HOLD);

  // Shadow including the byte being captured this cycle, so verify sees the final byte.
  always_comb begin
    shadow_nxt = shadow;
    if (state == RD_CAPT) shadow_nxt[{byte_idx, 3'b000} +: 8] = efuse_rdata_i;
  end

  assign win_now  = shadow_nxt[wr_bit_base +: NW];
  assign fail_vec = wdata_q & ~win_now;
  assign fail_any = |fail_vec;
  assign retry_ok = (attempt <= 8'(MAX_RETRY));

  assign tmr_load = (state == RD_SETUP) || (state == PG_SETUP);
  assign tmr_len  = (state == PG_SETUP) ? tpgm : TPGM_W'(trd);

  efuse_strobe_timer #(.W(TPGM_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_al || start_rd) state_nxt = RD_SETUP;
        else if (start_wr)        state_nxt = PG_SCAN;
      end
      RD_SETUP:  state_nxt = RD_STROBE;
      RD_STROBE: if (tmr_exp) state_nxt = RD_CAPT;
      RD_CAPT: begin
        if (!last_byte)                                      state_nxt = RD_SETUP;
        else if ((mode == MODE_WRITE) && fail_any && retry_ok) state_nxt = PG_SCAN;
        else                                                 state_nxt = DONE;
      end
      PG_SCAN: begin
        if (pg_mask[bit_idx]) state_nxt = PG_SETUP;
        else if (bit_last)    state_nxt = RD_SETUP;
      end
      PG_SETUP:  state_nxt = PG_STROBE;
      PG_STROBE: if (tmr_exp) state_nxt = PG_HOLD;
      PG_HOLD:   state_nxt = bit_last ? RD_SETUP : PG_SCAN;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Macro strobes and status decoded from the current state.
  always_comb begin
    efuse_pgmen_o = 1'b0;
    efuse_rden_o  = 1'b0;
    efuse_aen_o   = 1'b0;
    efuse_addr_o  = '0;
    case (state)
      RD_SETUP, RD_CAPT: begin
        efuse_rden_o = 1'b1;
        efuse_addr_o = {byte_idx, 3'b000};
      end
      RD_STROBE: begin
        efuse_rden_o = 1'b1;
        efuse_aen_o  = 1'b1;
        efuse_addr_o = {byte_idx, 3'b000};
      end
      PG_SETUP, PG_HOLD: begin
        efuse_pgmen_o = 1'b1;
        efuse_addr_o  = wr_bit_base + AW'(bit_idx);
      end
      PG_STROBE: begin
        efuse_pgmen_o = 1'b1;
        efuse_aen_o   = 1'b1;
        efuse_addr_o  = wr_bit_base + AW'(bit_idx);
      end
      default: ;
    endcase
    busy     = (state != IDLE);
    cmd_done = (state == DONE) && (mode != MODE_AUTO);
  end

  // Sequencing counters, latched command fields, shadow and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode          <= MODE_AUTO;
      byte_idx      <= '0;
      byte_last     <= '0;
      bit_idx       <= '0;
      wdata_q       <= '0;
      pg_mask       <= '0;
      wsel_q        <= '0;
      attempt       <= '0;
      shadow        <= '0;
      autoload_done <= 1'b0;
      verify_err    <= 1'b0;
      pwd_err       <= 1'b0;
    end else begin
      pwd_err <= pwd_bad;
      shadow  <= shadow_nxt;
      if (start_cmd) verify_err <= 1'b0;

      if (start_al) begin
        mode          <= MODE_AUTO;
        byte_idx      <= '0;
        byte_last     <= BW'(NBYTES - 1);
        autoload_done <= 1'b0;
      end else if (start_rd) begin
        mode      <= MODE_READ;
        byte_idx  <= rd_bit_base[AW-1:3];
        byte_last <= rd_bit_base[AW-1:3] + BW'(NR_BYTES - 1);
      end else if (start_wr) begin
        mode    <= MODE_WRITE;
        wdata_q <= wdata;
        pg_mask <= wdata;
        wsel_q  <= write_sel;
        bit_idx <= '0;
        attempt <= 8'd1;
      end

      if (state == RD_CAPT) begin
        if (!last_byte) begin
          byte_idx <= byte_idx + BW'(1);
        end else begin
          if (mode == MODE_AUTO) autoload_done <= 1'b1;
          if ((mode == MODE_WRITE) && fail_any) begin
            if (retry_ok) begin
              attempt <= attempt + 8'd1;
              pg_mask <= fail_vec;
              bit_idx <= '0;
            end else begin
              verify_err <= 1'b1;
            end
          end
        end
      end

      // Advance to the next bit, or set up the verify readback after the last one.
      if (bit_step) begin
        if (bit_last) begin
          byte_idx  <= wr_bit_base[AW-1:3];
          byte_last <= wr_bit_base[AW-1:3] + BW'(NW_BYTES - 1);
        end else begin
          bit_idx <= bit_idx + NWB'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_efuse_ctrl_pv.sv
// Directed bench for efuse_ctrl_pv with a behavioural eFuse macro model.
module tb_efuse_ctrl_pv;

  localparam logic [15:0] KEY = 16'h55AA;

  logic         clk = 1'b0;
  logic         rst, autoload_start, cmd_start, cmd_write;
  logic [15:0]  password;
  logic [63:0]  wdata;
  logic [1:0]   read_sel, write_sel;
  logic [5:0]   trd;
  logic [9:0]   tpgm;
  logic [63:0]  rdata;
  logic         pgmen, rden, aen;
  logic [7:0]   addr;
  logic [7:0]   frd;
  logic         autoload_done, busy, cmd_done, verify_err, pwd_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  efuse_ctrl_pv dut (
    .clk            (clk),
    .rst            (rst),
    .autoload_start (autoload_start),
    .cmd_start      (cmd_start),
    .cmd_write      (cmd_write),
    .password       (password),
    .wdata          (wdata),
    .read_sel       (read_sel),
    .write_sel      (write_sel),
    .trd            (trd),
    .tpgm           (tpgm),
    .rdata          (rdata),
    .efuse_pgmen_o  (pgmen),
    .efuse_rden_o   (rden),
    .efuse_aen_o    (aen),
    .efuse_addr_o   (addr),
    .efuse_rdata_i  (frd),
    .autoload_done  (autoload_done),
    .busy           (busy),
    .cmd_done       (cmd_done),
    .verify_err     (verify_err),
    .pwd_err        (pwd_err)
  );

  // Macro model: byte reads, bit blows on program strobe, optional stuck bit 65.
  logic [255:0] fuse, fuse_init;
  logic         fuse_load, force_a5, stuck65;
  assign frd = force_a5 ? 8'hA5 : fuse[addr +: 8];

  always @(posedge clk) begin
    if (fuse_load) fuse <= fuse_init;
    else if (pgmen && aen && !(stuck65 && addr == 8'd65)) fuse[addr] <= 1'b1;
  end

  // Activity monitor (cumulative counters).
  int pg_pulse [256];
  int pg_cyc   [256];
  int pg_tot = 0, rd_pulse = 0, rd_cyc = 0, done_cnt = 0, pwd_cnt = 0;
  int busy_cnt = 0, act_cnt = 0, overlap_cnt = 0;
  bit aen_d = 1'b0;

  always @(posedge clk) begin
    aen_d <= aen;
    if (pgmen && aen && !aen_d) begin
      pg_pulse[addr] <= pg_pulse[addr] + 1;
      pg_tot         <= pg_tot + 1;
    end
    if (pgmen && aen)          pg_cyc[addr] <= pg_cyc[addr] + 1;
    if (rden && aen && !aen_d) rd_pulse <= rd_pulse + 1;
    if (rden && aen)           rd_cyc <= rd_cyc + 1;
    if (cmd_done)              done_cnt <= done_cnt + 1;
    if (pwd_err)               pwd_cnt <= pwd_cnt + 1;
    if (busy)                  busy_cnt <= busy_cnt + 1;
    if (pgmen || rden || aen)  act_cnt <= act_cnt + 1;
    if (pgmen && rden)         overlap_cnt <= overlap_cnt + 1;
  end

  int b_pg64, b_pg65, b_cy64, b_cy65, b_pgtot, b_rdp, b_rdc, b_done, b_pwd, b_busy, b_act;

  task automatic snap();
    b_pg64 = pg_pulse[64]; b_pg65 = pg_pulse[65];
    b_cy64 = pg_cyc[64];   b_cy65 = pg_cyc[65];
    b_pgtot = pg_tot; b_rdp = rd_pulse; b_rdc = rd_cyc;
    b_done = done_cnt; b_pwd = pwd_cnt; b_busy = busy_cnt; b_act = act_cnt;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_fuse(input logic [255:0] v);
    fuse_init = v;
    fuse_load = 1'b1;
    @(posedge clk); #1;
    fuse_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_al(output int n);
    n = 0;
    while (!autoload_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic start_write(input logic [15:0] pw, input logic [63:0] wd, input logic [1:0] ws);
    @(negedge clk);
    cmd_start = 1'b1; cmd_write = 1'b1; password = pw; wdata = wd; write_sel = ws;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [255:0] pat;
    logic [63:0]  exp_w;

    rst = 1'b1; autoload_start = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
    password = 16'h0; wdata = 64'h0; read_sel = 2'd0; write_sel = 2'd0;
    trd = 6'd3; tpgm = 10'd3;
    fuse_init = '0; fuse_load = 1'b1; force_a5 = 1'b0; stuck65 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; fuse_load = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_al_done", {63'd0, autoload_done}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_strobes", {61'd0, pgmen, rden, aen}, 64'd0);
    chk("rst_flags", {61'd0, cmd_done, verify_err, pwd_err}, 64'd0);

    // Autoload, trd=3, macro returns A5 everywhere: 32 bytes x 5 cycles
    force_a5 = 1'b1;
    snap();
    @(negedge clk); autoload_start = 1'b1;
    @(posedge clk); #1; autoload_start = 1'b0;
    wait_al(n);
    chk("al_latency", 64'(n), 64'd160);
    wait_idle("al_idle");
    read_sel = 2'd0; #1;
    chk("al_rdata_w0", rdata, {8{8'hA5}});
    read_sel = 2'd3; #1;
    chk("al_rdata_w3", rdata, {8{8'hA5}});
    chk("al_rd_pulses", 64'(rd_pulse - b_rdp), 64'd32);
    chk("al_rd_cycles", 64'(rd_cyc - b_rdc), 64'd96);
    chk("al_no_pgm", 64'(pg_tot - b_pgtot), 64'd0);
    force_a5 = 1'b0;

    // Good write of bits 64,65
    load_fuse('0);
    snap();
    start_write(KEY, 64'h3, 2'd1);
    chk("wr_busy", {63'd0, busy}, 64'd1);
    wait_idle("wr_idle");
    chk("wr_pg_total", 64'(pg_tot - b_pgtot), 64'd2);
    chk("wr_pg64", 64'(pg_pulse[64] - b_pg64), 64'd1);
    chk("wr_pg65", 64'(pg_pulse[65] - b_pg65), 64'd1);
    chk("wr_cyc64", 64'(pg_cyc[64] - b_cy64), 64'd3);
    chk("wr_cyc65", 64'(pg_cyc[65] - b_cy65), 64'd3);
    chk("wr_readback", 64'(rd_pulse - b_rdp), 64'd8);
    chk("wr_done", 64'(done_cnt - b_done), 64'd1);
    chk("wr_verify_err", {63'd0, verify_err}, 64'd0);
    read_sel = 2'd1; #1;
    chk("wr_rdata", rdata, 64'h3);

    // Same write with bit 65 stuck at 0
    load_fuse('0);
    stuck65 = 1'b1;
    snap();
    start_write(KEY, 64'h3, 2'd1);
    wait_idle("st_idle");
    chk("st_pg65", 64'(pg_pulse[65] - b_pg65), 64'd3);
    chk("st_pg64", 64'(pg_pulse[64] - b_pg64), 64'd1);
    chk("st_done", 64'(done_cnt - b_done), 64'd1);
    chk("st_verify_err", {63'd0, verify_err}, 64'd1);
    chk("st_rdata", rdata, 64'h1);
    repeat (3) @(posedge clk); #1;
    chk("st_verify_sticky", {63'd0, verify_err}, 64'd1);
    stuck65 = 1'b0;

    // Wrong password
    snap();
    start_write(16'h1234, 64'hFF, 2'd1);
    repeat (6) @(posedge clk); #1;
    chk("pw_err_pulses", 64'(pwd_cnt - b_pwd), 64'd1);
    chk("pw_busy", 64'(busy_cnt - b_busy), 64'd0);
    chk("pw_activity", 64'(act_cnt - b_act), 64'd0);
    chk("pw_no_done", 64'(done_cnt - b_done), 64'd0);
    chk("pw_verr_clr", {63'd0, verify_err}, 64'd0);

    // Reset during a program strobe
    load_fuse('0);
    start_write(KEY, 64'h3, 2'd1);
    n = 0;
    while (!(pgmen && aen) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rs_reach_strobe", {63'd0, pgmen && aen}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_pgmen_aen", {62'd0, pgmen, aen}, 64'd0);
    chk("rs_busy", {63'd0, busy}, 64'd0);
    chk("rs_al_done", {63'd0, autoload_done}, 64'd0);
    read_sel = 2'd0; #1;
    chk("rs_shadow_w0", rdata, 64'd0);
    read_sel = 2'd1; #1;
    chk("rs_shadow_w1", rdata, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Autoload and write command in the same cycle, trd=0
    for (int b = 0; b < 32; b++) pat[b*8 +: 8] = 8'(b * 37 + 11);
    load_fuse(pat);
    trd = 6'd0;
    snap();
    @(negedge clk);
    autoload_start = 1'b1; cmd_start = 1'b1; cmd_write = 1'b1;
    password = KEY; wdata = '1; write_sel = 2'd0;
    @(posedge clk); #1;
    autoload_start = 1'b0; cmd_start = 1'b0;
    wait_al(n);
    chk("ar_latency", 64'(n), 64'd96);
    wait_idle("ar_idle");
    chk("ar_rd_pulses", 64'(rd_pulse - b_rdp), 64'd32);
    chk("ar_rd_cycles", 64'(rd_cyc - b_rdc), 64'd32);
    chk("ar_no_pgm", 64'(pg_tot - b_pgtot), 64'd0);
    chk("ar_no_done", 64'(done_cnt - b_done), 64'd0);
    for (int b = 16; b < 24; b++) exp_w[(b-16)*8 +: 8] = 8'(b * 37 + 11);
    read_sel = 2'd2; #1;
    chk("ar_rdata_w2", rdata, exp_w);

    chk("no_pgm_rd_overlap", 64'(overlap_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
